// File: rtl/lc3_pkg.sv
// Shared opcodes, sequencer states and EAB select encodings for the LC-3 memory-access path.
package lc3_pkg;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LEA = 4'b1110;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_STR = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EA     = 3'd1,
        S_RD     = 3'd2,
        S_RD_IND = 3'd3,
        S_WR     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    typedef enum logic {
        SEL1_PC = 1'b0,
        SEL1_RA = 1'b1
    } sel1_t;

    typedef enum logic [1:0] {
        SEL2_ZERO  = 2'd0,
        SEL2_OFF6  = 2'd1,
        SEL2_OFF9  = 2'd2,
        SEL2_OFF11 = 2'd3
    } sel2_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return op inside {OP_LD, OP_LDI, OP_LDR, OP_LEA, OP_ST, OP_STI, OP_STR};
    endfunction

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if (v[15])
            return 3'b100;
        else if (v == 16'h0000)
            return 3'b010;
        return 3'b001;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Purpose: per-transaction wait counter; expired flags the last allowed wait cycle.
// Latency: expired is combinational from the count; clear takes effect next cycle.
// Backpressure: none; counts only while enabled, TIMEOUT=0 never expires.
module mem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/lc3_mem_access_ctrl.sv
// Purpose: sequences LC-3 LD/LDI/LDR/LEA/ST/STI/STR through EAB address capture and req/ack memory cycles.
// Latency: LEA 2, LD/LDR/ST/STR 3, LDI/STI 4 cycles from accept (zero-wait ack); each wait adds one.
// Backpressure: one instruction in flight; start is ignored while ready is low, mem waits bounded by TIMEOUT.
module lc3_mem_access_ctrl
    import lc3_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        ready,
    input  logic [15:0] IR,
    input  logic [15:0] PC,
    input  logic [15:0] Ra,
    input  logic [15:0] sr_data,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic [15:0] eab_pc,
    output logic [15:0] eab_ra,
    output logic [10:0] eab_ir,
    input  logic [15:0] eabOut,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        done,
    output logic        err,
    output logic        wb_en,
    output logic [2:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic [2:0]  nzp
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d, pc_q, pc_d, ra_q, ra_d, sr_q, sr_d;
    logic [15:0] addr_q, addr_d, wb_data_q, wb_data_d;
    sel1_t       sel1_q, sel1_d;
    sel2_t       sel2_q, sel2_d;
    logic        ready_q, ready_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic        done_q, done_d, err_q, err_d, wb_en_q, wb_en_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [3:0]  op;
    logic        tmo_clr, tmo_expired;

    assign op = ir_q[15:12];

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmo_clr),
        .en      (mem_req_q),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        ra_d      = ra_q;
        sr_d      = sr_q;
        addr_d    = addr_q;
        wb_data_d = wb_data_q;
        nzp_d     = nzp_q;
        wb_en_d   = 1'b0;
        err_d     = 1'b0;
        sel1_d    = SEL1_PC;
        sel2_d    = SEL2_ZERO;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ir_d = IR;
                    pc_d = PC;
                    ra_d = Ra;
                    sr_d = sr_data;
                    if (is_mem_op(IR[15:12])) begin
                        state_d = S_EA;
                        // Selects are registered, so they are decoded from the incoming IR.
                        if (IR[15:12] == OP_LDR || IR[15:12] == OP_STR) begin
                            sel1_d = SEL1_RA;
                            sel2_d = SEL2_OFF6;
                        end else begin
                            sel2_d = SEL2_OFF9;
                        end
                    end else begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_EA: begin
                addr_d = eabOut;
                case (op)
                    OP_LEA: begin
                        wb_data_d = eabOut;
                        wb_en_d   = 1'b1;
                        state_d   = S_DONE;
                    end
                    OP_ST, OP_STR: state_d = S_WR;
                    default:       state_d = S_RD;
                endcase
            end
            S_RD: begin
                if (mem_ack) begin
                    if (op == OP_LDI) begin
                        addr_d  = mem_rdata;
                        state_d = S_RD_IND;
                    end else if (op == OP_STI) begin
                        addr_d  = mem_rdata;
                        state_d = S_WR;
                    end else begin
                        wb_data_d = mem_rdata;
                        wb_en_d   = 1'b1;
                        state_d   = S_DONE;
                    end
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RD_IND: begin
                if (mem_ack) begin
                    wb_data_d = mem_rdata;
                    wb_en_d   = 1'b1;
                    state_d   = S_DONE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (wb_en_d)
            nzp_d = nzp_of(wb_data_d);

        // Every exit from a memory state is a state change, so this also restarts the wait count.
        tmo_clr   = (state_d != state_q);
        mem_req_d = state_d inside {S_RD, S_RD_IND, S_WR};
        mem_we_d  = (state_d == S_WR);
        done_d    = (state_d == S_DONE);
        ready_d   = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            pc_q      <= '0;
            ra_q      <= '0;
            sr_q      <= '0;
            addr_q    <= '0;
            wb_data_q <= '0;
            nzp_q     <= '0;
            sel1_q    <= SEL1_PC;
            sel2_q    <= SEL2_ZERO;
            ready_q   <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wb_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            ra_q      <= ra_d;
            sr_q      <= sr_d;
            addr_q    <= addr_d;
            wb_data_q <= wb_data_d;
            nzp_q     <= nzp_d;
            sel1_q    <= sel1_d;
            sel2_q    <= sel2_d;
            ready_q   <= ready_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wb_en_q   <= wb_en_d;
        end
    end

    assign ready     = ready_q;
    assign selEAB1   = sel1_q;
    assign selEAB2   = sel2_q;
    assign eab_pc    = pc_q;
    assign eab_ra    = ra_q;
    assign eab_ir    = ir_q[10:0];
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = sr_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wb_en     = wb_en_q;
    assign wb_reg    = ir_q[11:9];
    assign wb_data   = wb_data_q;
    assign nzp       = nzp_q;

endmodule
